eei_host_controller: RTL and testbench
======================================

# eei_host_controller

Byte-stream command interpreter that sits directly upstream of the RV32IMF single-cycle core and drives its execution-environment-interface (EEI) ports. It receives framed commands from a UART receiver, loads program and data memory, reads back data memory and registers, and launches a program run. It returns acknowledgements, results and the core's exit status to a UART transmitter. All core-side handshakes are owned here; the core itself is unchanged.

## Interface
- TIMEOUT_CYCLES, 1_000_000: max idle cycles between bytes of one command before abort.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  rx_data valid; byte consumed when rx_valid & rx_ready.
- rx_ready  out  1  controller can accept a byte.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data valid; held stable until tx_ready.
- tx_ready  in  1  transmitter accepted byte.
- start  out  1  to core; held high for the whole run.
- initial_PC  out  32  to core; run start address.
- ready, exit_status  in  1, 2  from core.
- PC  in  32  from core.
- acces_to_prog_mem, prog_valid_mem_fromEEI, prog_rw_fromEEI  out  1 each  program memory access control.
- prog_addr_fromEEI, prog_in_fromEEI  out  32 each  program memory address and write data.
- prog_ready_toEEI, prog_out_of_range_toEEI  in  1 each  program memory completion and error.
- acces_to_data_mem, data_valid_mem_fromEEI, data_rw_fromEEI  out  1 each  data memory access control.
- data_addr_fromEEI, data_in_fromEEI  out  32 each  data memory address and write data.
- data_ready_toEEI, data_out_of_range_toEEI  in  1 each  data memory completion and error.
- data_out_toEEI  in  32  data memory read data.
- acces_to_registers_files, is_rs1_fp_fromEEI  out  1 each  register file read access.
- rs1_add_fromEEI  out  5  register file read address.
- rs1_toEEI  in  32  register file read data.
- Tied constants: byte_half_word = 2'b00, is_load_unsigned = 1, do_wb_fromEEI = 0.

## Operation
- Command frame is one opcode byte followed by argument bytes; all multi-byte fields are little-endian.
- Commands:
  - 0x01 WPROG: addr[4], data[4]. Word write to program memory.
  - 0x02 WDATA: addr[4], data[4]. Word write to data memory.
  - 0x03 RDATA: addr[4]. Word read from data memory.
  - 0x04 RUN: pc[4]. Launch program at pc.
  - 0x05 RREG: idx[1]. idx[5] selects fp, idx[4:0] is the register address.
- Replies:
  - ACK = 0xA0.
  - Memory out of range = 0xE1.
  - Timeout = 0xE2.
  - Unknown opcode = 0xEE; no argument bytes are consumed.
- States:
  - IDLE: rx_ready=1. Opcode byte goes to GET_ARGS, or to SEND(0xEE) if unknown.
  - GET_ARGS: shift bytes into a 64-bit argument register; byte counter counts down to 0, then dispatch.
  - MEM_ACC: access flag and address/data valid from entry; valid_mem high until ready or out_of_range is sampled high. ready produces ACK plus read data on RDATA. out_of_range produces 0xE1. Then valid deasserts and access flag drops.
  - REG_ACC: drive acces_to_registers_files and address for 2 cycles; capture rs1_toEEI in the 2nd.
  - RUN_WAIT: initial_PC=pc, start=1 until ready sampled high. Then latch exit_status and PC, and drop start the next cycle.
  - SEND: emits the reply buffer (1 to 6 bytes) one byte per tx handshake, then returns to IDLE.
- Reply lengths:
  - WPROG, WDATA: ACK (1 byte).
  - RDATA, RREG: ACK + 4 data bytes.
  - RUN: ACK + {6'b0, exit_status} + PC[4] (6 bytes).
- During RUN all acces_to_* outputs are 0; the core gates them with start regardless.
- rx_ready is 0 outside IDLE and GET_ARGS. Bytes arriving during processing are back-pressured, never dropped.

## Timing
- Reset values: all outputs 0, initial_PC = 0, tx_data = 0, state IDLE. The inter-byte timeout counter is cleared.
- Reset mid-run drops start in the cycle after rst is sampled, so the core returns to its waiting state. A partial reply is discarded.
- Byte acceptance costs 1 cycle. Dispatch occurs the cycle after the last argument byte.
- Memory access latency equals the core memory's response time plus 1 cycle to register the result.
- RREG takes a fixed 2 cycles.
- If ready and out_of_range are sampled high together, out_of_range wins.
- Timeout: in GET_ARGS, a counter reaching TIMEOUT_CYCLES-1 with no new byte sends 0xE2 and returns to IDLE. The counter reloads on every accepted byte.
- RUN has no timeout; completion is signalled only by the core's ready.
- tx_valid stays asserted with stable tx_data until tx_ready; the next byte is presented the cycle after the handshake.

## Test plan
- WPROG addr=0x00000000 data=0x00500093 -> prog_valid pulse at addr 0, single reply 0xA0.
- WDATA 0x10, 0xDEADBEEF, then RDATA 0x10 -> replies A0, then A0 EF BE AD DE.
- RDATA addr=0xFFFFFFF0 with out_of_range asserted -> reply 0xE1, acces_to_data_mem back to 0.
- RUN pc=0 with program "addi x1,x0,5; ecall" -> start held until ready, reply A0 00 04 00 00 00. RREG 0x01 then returns A0 05 00 00 00.
- Opcode 0x7F -> reply 0xEE. WPROG with only 3 bytes, then silence (TIMEOUT_CYCLES=16) -> 0xE2 after 16 idle cycles.
- Assert rst mid-RUN and mid-SEND with tx_ready held low -> all outputs 0 the next cycle, IDLE accepts a new opcode.

Source files
------------

// File: rtl/eei_host_controller.sv
// Byte-stream command interpreter driving the RV32IMF core's EEI ports:
// loads/reads memories, reads registers, launches runs and reports results.
module eei_host_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        start,
  output logic [31:0] initial_PC,
  input  logic        ready,
  input  logic [1:0]  exit_status,
  input  logic [31:0] PC,
  output logic        acces_to_prog_mem,
  output logic        prog_valid_mem_fromEEI,
  output logic        prog_rw_fromEEI,
  output logic [31:0] prog_addr_fromEEI,
  output logic [31:0] prog_in_fromEEI,
  input  logic        prog_ready_toEEI,
  input  logic        prog_out_of_range_toEEI,
  output logic        acces_to_data_mem,
  output logic        data_valid_mem_fromEEI,
  output logic        data_rw_fromEEI,
  output logic [31:0] data_addr_fromEEI,
  output logic [31:0] data_in_fromEEI,
  input  logic        data_ready_toEEI,
  input  logic        data_out_of_range_toEEI,
  input  logic [31:0] data_out_toEEI,
  output logic        acces_to_registers_files,
  output logic        is_rs1_fp_fromEEI,
  output logic [4:0]  rs1_add_fromEEI,
  input  logic [31:0] rs1_toEEI,
  output logic [1:0]  byte_half_word,
  output logic        is_load_unsigned,
  output logic        do_wb_fromEEI
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] OP_WPROG = 8'h01;
  localparam logic [7:0] OP_WDATA = 8'h02;
  localparam logic [7:0] OP_RDATA = 8'h03;
  localparam logic [7:0] OP_RUN   = 8'h04;
  localparam logic [7:0] OP_RREG  = 8'h05;

  localparam logic [7:0] RSP_ACK = 8'hA0;
  localparam logic [7:0] RSP_OOR = 8'hE1;
  localparam logic [7:0] RSP_TMO = 8'hE2;
  localparam logic [7:0] RSP_BAD = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_ARGS,
    S_MEM_ACC,
    S_REG_ACC,
    S_RUN_WAIT,
    S_SEND
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    op_q, op_d;
  logic [63:0]   args_q, args_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [47:0]   reply_q, reply_d;
  logic [2:0]    len_q, len_d;
  logic          regc_q, regc_d;
  logic [31:0]   run_pc_q, run_pc_d;

  logic        mem_active, is_prog, is_write;
  logic        mem_rdy, mem_oor;
  logic [31:0] mem_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      args_q   <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      reply_q  <= '0;
      len_q    <= '0;
      regc_q   <= 1'b0;
      run_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      args_q   <= args_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      reply_q  <= reply_d;
      len_q    <= len_d;
      regc_q   <= regc_d;
      run_pc_q <= run_pc_d;
    end
  end

  // Arguments shift in from the top, so 8-byte frames hold addr in [31:0]
  // while 4-byte frames end up in [63:32] and the 1-byte index in [63:56].
  assign is_prog  = (op_q == OP_WPROG);
  assign is_write = (op_q != OP_RDATA);
  assign mem_addr = is_write ? args_q[31:0] : args_q[63:32];
  assign mem_rdy  = is_prog ? prog_ready_toEEI : data_ready_toEEI;
  assign mem_oor  = is_prog ? prog_out_of_range_toEEI : data_out_of_range_toEEI;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    args_d   = args_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    reply_d  = reply_q;
    len_d    = len_q;
    regc_d   = regc_q;
    run_pc_d = run_pc_q;

    case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (rx_valid) begin
          op_d = rx_data;
          case (rx_data)
            OP_WPROG, OP_WDATA: begin cnt_d = 4'd8; state_d = S_GET_ARGS; end
            OP_RDATA, OP_RUN:   begin cnt_d = 4'd4; state_d = S_GET_ARGS; end
            OP_RREG:            begin cnt_d = 4'd1; state_d = S_GET_ARGS; end
            default: begin
              reply_d = {40'h0, RSP_BAD};
              len_d   = 3'd1;
              state_d = S_SEND;
            end
          endcase
        end
      end

      S_GET_ARGS: begin
        if (rx_valid) begin
          args_d = {rx_data, args_q[63:8]};
          cnt_d  = cnt_q - 4'd1;
          tmo_d  = '0;
          if (cnt_q == 4'd1) begin
            case (op_q)
              OP_RUN: begin
                run_pc_d = args_d[63:32];
                state_d  = S_RUN_WAIT;
              end
              OP_RREG: begin
                regc_d  = 1'b0;
                state_d = S_REG_ACC;
              end
              default: state_d = S_MEM_ACC;
            endcase
          end
        end else if (tmo_q == TMO_LAST) begin
          reply_d = {40'h0, RSP_TMO};
          len_d   = 3'd1;
          state_d = S_SEND;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      // Out-of-range takes priority when both completion flags arrive together.
      S_MEM_ACC: begin
        if (mem_oor) begin
          reply_d = {40'h0, RSP_OOR};
          len_d   = 3'd1;
          state_d = S_SEND;
        end else if (mem_rdy) begin
          if (is_write) begin
            reply_d = {40'h0, RSP_ACK};
            len_d   = 3'd1;
          end else begin
            reply_d = {8'h0, data_out_toEEI, RSP_ACK};
            len_d   = 3'd5;
          end
          state_d = S_SEND;
        end
      end

      S_REG_ACC: begin
        if (!regc_q) begin
          regc_d = 1'b1;
        end else begin
          reply_d = {8'h0, rs1_toEEI, RSP_ACK};
          len_d   = 3'd5;
          state_d = S_SEND;
        end
      end

      S_RUN_WAIT: begin
        if (ready) begin
          reply_d = {PC, 6'b0, exit_status, RSP_ACK};
          len_d   = 3'd6;
          state_d = S_SEND;
        end
      end

      S_SEND: begin
        if (tx_ready) begin
          reply_d = {8'h0, reply_q[47:8]};
          len_d   = len_q - 3'd1;
          if (len_q == 3'd1) state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign mem_active = (state_q == S_MEM_ACC);

  // rx_ready is masked by rst so every output reads zero while reset is held.
  assign rx_ready = ~rst & ((state_q == S_IDLE) | (state_q == S_GET_ARGS));
  assign tx_valid = (state_q == S_SEND);
  assign tx_data  = (state_q == S_SEND) ? reply_q[7:0] : 8'h00;

  assign start      = (state_q == S_RUN_WAIT);
  assign initial_PC = run_pc_q;

  assign acces_to_prog_mem      = mem_active & is_prog;
  assign prog_valid_mem_fromEEI = mem_active & is_prog;
  assign prog_rw_fromEEI        = mem_active & is_prog & is_write;
  assign prog_addr_fromEEI      = (mem_active & is_prog) ? mem_addr : 32'h0;
  assign prog_in_fromEEI        = (mem_active & is_prog) ? args_q[63:32] : 32'h0;

  assign acces_to_data_mem      = mem_active & ~is_prog;
  assign data_valid_mem_fromEEI = mem_active & ~is_prog;
  assign data_rw_fromEEI        = mem_active & ~is_prog & is_write;
  assign data_addr_fromEEI      = (mem_active & ~is_prog) ? mem_addr : 32'h0;
  assign data_in_fromEEI        = (mem_active & ~is_prog & is_write) ? args_q[63:32] : 32'h0;

  assign acces_to_registers_files = (state_q == S_REG_ACC);
  assign rs1_add_fromEEI          = (state_q == S_REG_ACC) ? args_q[60:56] : 5'h0;
  assign is_rs1_fp_fromEEI        = (state_q == S_REG_ACC) & args_q[61];

  assign byte_half_word   = 2'b00;
  assign is_load_unsigned = 1'b1;
  assign do_wb_fromEEI    = 1'b0;

endmodule

// File: tb/tb_eei_host_controller.sv
// Directed self-checking bench for eei_host_controller: drives command frames
// byte by byte, plays the memories/core by hand, and checks every reply.
module tb_eei_host_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        start;
  logic [31:0] initial_PC;
  logic        ready;
  logic [1:0]  exit_status;
  logic [31:0] PC;
  logic        acces_to_prog_mem, prog_valid_mem_fromEEI, prog_rw_fromEEI;
  logic [31:0] prog_addr_fromEEI, prog_in_fromEEI;
  logic        prog_ready_toEEI, prog_out_of_range_toEEI;
  logic        acces_to_data_mem, data_valid_mem_fromEEI, data_rw_fromEEI;
  logic [31:0] data_addr_fromEEI, data_in_fromEEI;
  logic        data_ready_toEEI, data_out_of_range_toEEI;
  logic [31:0] data_out_toEEI;
  logic        acces_to_registers_files, is_rs1_fp_fromEEI;
  logic [4:0]  rs1_add_fromEEI;
  logic [31:0] rs1_toEEI;
  logic [1:0]  byte_half_word;
  logic        is_load_unsigned, do_wb_fromEEI;

  int errors = 0;
  int checks = 0;

  eei_host_controller #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .start(start), .initial_PC(initial_PC),
    .ready(ready), .exit_status(exit_status), .PC(PC),
    .acces_to_prog_mem(acces_to_prog_mem),
    .prog_valid_mem_fromEEI(prog_valid_mem_fromEEI),
    .prog_rw_fromEEI(prog_rw_fromEEI),
    .prog_addr_fromEEI(prog_addr_fromEEI),
    .prog_in_fromEEI(prog_in_fromEEI),
    .prog_ready_toEEI(prog_ready_toEEI),
    .prog_out_of_range_toEEI(prog_out_of_range_toEEI),
    .acces_to_data_mem(acces_to_data_mem),
    .data_valid_mem_fromEEI(data_valid_mem_fromEEI),
    .data_rw_fromEEI(data_rw_fromEEI),
    .data_addr_fromEEI(data_addr_fromEEI),
    .data_in_fromEEI(data_in_fromEEI),
    .data_ready_toEEI(data_ready_toEEI),
    .data_out_of_range_toEEI(data_out_of_range_toEEI),
    .data_out_toEEI(data_out_toEEI),
    .acces_to_registers_files(acces_to_registers_files),
    .is_rs1_fp_fromEEI(is_rs1_fp_fromEEI),
    .rs1_add_fromEEI(rs1_add_fromEEI),
    .rs1_toEEI(rs1_toEEI),
    .byte_half_word(byte_half_word),
    .is_load_unsigned(is_load_unsigned),
    .do_wb_fromEEI(do_wb_fromEEI)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sigSel(input int which);
    case (which)
      0: return prog_valid_mem_fromEEI;
      1: return data_valid_mem_fromEEI;
      2: return start;
      3: return acces_to_registers_files;
      default: return tx_valid;
    endcase
  endfunction

  // Bounded wait at negedges for a DUT output to rise.
  task automatic waitSignal(input int which, input string tag);
    int n = 0;
    while (!sigSel(which) && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, sigSel(which), 1'b1);
  endtask

  // Offers one byte at a negedge and returns at the negedge after it was taken.
  task automatic applyStimulus(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rx_ready", rx_ready, 1'b1);
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic expectReply(input int n, input logic [47:0] val, input string tag);
    tx_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      waitSignal(4, {tag, "_txvalid"});
      checkOutput(tag, tx_data, val[i*8 +: 8]);
      @(negedge clk);
    end
    checkOutput({tag, "_end"}, tx_valid, 1'b0);
  endtask

  // Plays a memory: waits for valid, checks the request, answers after lat cycles.
  task automatic serveMem(input logic isProg, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic rw, input int lat, input logic rdy, input logic oor,
                          input string tag);
    waitSignal(isProg ? 0 : 1, {tag, "_valid"});
    if (isProg) begin
      checkOutput({tag, "_acc"}, acces_to_prog_mem, 1'b1);
      checkOutput({tag, "_addr"}, prog_addr_fromEEI, addr);
      checkOutput({tag, "_rw"}, prog_rw_fromEEI, rw);
      if (rw) checkOutput({tag, "_wdata"}, prog_in_fromEEI, wdata);
    end else begin
      checkOutput({tag, "_acc"}, acces_to_data_mem, 1'b1);
      checkOutput({tag, "_addr"}, data_addr_fromEEI, addr);
      checkOutput({tag, "_rw"}, data_rw_fromEEI, rw);
      if (rw) checkOutput({tag, "_wdata"}, data_in_fromEEI, wdata);
    end
    checkOutput({tag, "_rxbusy"}, rx_ready, 1'b0);
    repeat (lat) @(negedge clk);
    checkOutput({tag, "_hold"}, sigSel(isProg ? 0 : 1), 1'b1);
    if (isProg) begin
      prog_ready_toEEI = rdy;
      prog_out_of_range_toEEI = oor;
    end else begin
      data_ready_toEEI = rdy;
      data_out_of_range_toEEI = oor;
    end
    @(negedge clk);
    prog_ready_toEEI = 1'b0;
    prog_out_of_range_toEEI = 1'b0;
    data_ready_toEEI = 1'b0;
    data_out_of_range_toEEI = 1'b0;
    checkOutput({tag, "_accdrop"}, acces_to_prog_mem | acces_to_data_mem, 1'b0);
  endtask

  task automatic runProgram(input logic [31:0] pc, input logic [1:0] ex, input logic [31:0] endPc,
                            input string tag);
    applyStimulus(8'h04);
    for (int i = 0; i < 4; i++) applyStimulus(pc[i*8 +: 8]);
    waitSignal(2, {tag, "_start"});
    checkOutput({tag, "_ipc"}, initial_PC, pc);
    checkOutput({tag, "_noacc"},
                {acces_to_prog_mem, acces_to_data_mem, acces_to_registers_files}, 3'b000);
    checkOutput({tag, "_rxbusy"}, rx_ready, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput({tag, "_held"}, start, 1'b1);
    PC = endPc;
    exit_status = ex;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    PC = 32'hFFFF_FFFF;
    exit_status = 2'b11;
    checkOutput({tag, "_drop"}, start, 1'b0);
    expectReply(6, {endPc, 6'b0, ex, 8'hA0}, tag);
  endtask

  initial begin
    int idle;
    rst = 1'b1;
    rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b1;
    ready = 1'b0; exit_status = 2'b00; PC = 32'h0;
    prog_ready_toEEI = 1'b0; prog_out_of_range_toEEI = 1'b0;
    data_ready_toEEI = 1'b0; data_out_of_range_toEEI = 1'b0;
    data_out_toEEI = 32'h0; rs1_toEEI = 32'h0;

    repeat (3) @(negedge clk);
    checkOutput("rst_ctrl", {rx_ready, tx_valid, start, acces_to_prog_mem, acces_to_data_mem,
                             acces_to_registers_files}, 6'b0);
    checkOutput("rst_txdata", tx_data, 8'h00);
    checkOutput("rst_ipc", initial_PC, 32'h0);
    checkOutput("tied", {byte_half_word, is_load_unsigned, do_wb_fromEEI}, 4'b0010);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_rxready", rx_ready, 1'b1);

    $display("[TB] WPROG");
    applyStimulus(8'h01);
    for (int i = 0; i < 4; i++) applyStimulus(8'h00);
    applyStimulus(8'h93); applyStimulus(8'h00); applyStimulus(8'h50); applyStimulus(8'h00);
    serveMem(1'b1, 32'h0, 32'h0050_0093, 1'b1, 0, 1'b1, 1'b0, "wprog");
    expectReply(1, 48'hA0, "wprog_rsp");

    $display("[TB] WDATA / RDATA");
    applyStimulus(8'h02);
    applyStimulus(8'h10); applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h00);
    applyStimulus(8'hEF); applyStimulus(8'hBE); applyStimulus(8'hAD); applyStimulus(8'hDE);
    serveMem(1'b0, 32'h10, 32'hDEAD_BEEF, 1'b1, 2, 1'b1, 1'b0, "wdata");
    expectReply(1, 48'hA0, "wdata_rsp");
    applyStimulus(8'h03);
    applyStimulus(8'h10); applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h00);
    data_out_toEEI = 32'hDEAD_BEEF;
    serveMem(1'b0, 32'h10, 32'h0, 1'b0, 1, 1'b1, 1'b0, "rdata");
    data_out_toEEI = 32'h0;
    expectReply(5, 48'h00_DEAD_BEEF_A0, "rdata_rsp");

    $display("[TB] out of range");
    applyStimulus(8'h03);
    applyStimulus(8'hF0); applyStimulus(8'hFF); applyStimulus(8'hFF); applyStimulus(8'hFF);
    serveMem(1'b0, 32'hFFFF_FFF0, 32'h0, 1'b0, 0, 1'b0, 1'b1, "oor");
    expectReply(1, 48'hE1, "oor_rsp");
    applyStimulus(8'h02);
    for (int i = 0; i < 8; i++) applyStimulus(8'h11 * i);
    serveMem(1'b0, 32'h3322_1100, 32'h7766_5544, 1'b1, 0, 1'b1, 1'b1, "oorwin");
    expectReply(1, 48'hE1, "oorwin_rsp");

    $display("[TB] RUN / RREG");
    runProgram(32'h0, 2'b00, 32'h4, "run0");
    runProgram(32'h0000_0100, 2'b01, 32'h1234_5678, "run1");
    rs1_toEEI = 32'h5;
    applyStimulus(8'h05); applyStimulus(8'h01);
    waitSignal(3, "rreg_acc");
    checkOutput("rreg_addr", {is_rs1_fp_fromEEI, rs1_add_fromEEI}, 6'h01);
    @(negedge clk);
    checkOutput("rreg_acc2", acces_to_registers_files, 1'b1);
    @(negedge clk);
    checkOutput("rreg_acc3", acces_to_registers_files, 1'b0);
    expectReply(5, 48'h00_0000_0005_A0, "rreg_rsp");
    rs1_toEEI = 32'h4049_0FDB;
    applyStimulus(8'h05); applyStimulus(8'h23);
    waitSignal(3, "rregf_acc");
    checkOutput("rregf_addr", {is_rs1_fp_fromEEI, rs1_add_fromEEI}, 6'h23);
    expectReply(5, 48'h00_4049_0FDB_A0, "rregf_rsp");

    $display("[TB] bad opcode / timeout");
    applyStimulus(8'h7F);
    expectReply(1, 48'hEE, "badop");
    applyStimulus(8'h01); applyStimulus(8'h00); applyStimulus(8'h00);
    idle = 0;
    while (!tx_valid && idle < 40) begin
      @(negedge clk);
      idle++;
    end
    checkOutput("tmo_cycles", idle, 16);
    expectReply(1, 48'hE2, "tmo_rsp");

    $display("[TB] reset mid-run / mid-send");
    applyStimulus(8'h04);
    for (int i = 0; i < 4; i++) applyStimulus(8'h00);
    waitSignal(2, "rstrun_start");
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstrun_out", {start, tx_valid, rx_ready}, 3'b000);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstrun_idle", rx_ready, 1'b1);
    tx_ready = 1'b0;
    rs1_toEEI = 32'h1122_3344;
    applyStimulus(8'h05); applyStimulus(8'h02);
    waitSignal(4, "rstsend_tx");
    checkOutput("rstsend_b0", tx_data, 8'hA0);
    repeat (2) @(negedge clk);
    checkOutput("rstsend_stable", {tx_valid, tx_data}, 9'h1A0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstsend_out", {tx_valid, tx_data, rx_ready}, 10'h0);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(8'h7F);
    expectReply(1, 48'hEE, "postrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
